toggle_decoder: RTL and testbench

- Receive end of a toggle-signalled event line, such as the output of the team's T flip-flop: every level change on `toggle_in` is one event.
- Turns each transition into a one-cycle `pulse_out` and counts events in a saturating counter.
- A watchdog state machine reports whether the line is idle, actively toggling, or stalled.
- Sits downstream of a toggle source, in the same clock domain or across a domain boundary when the synchronizer is compiled in.

---
 rtl/toggle_decoder.sv | 133 +++++++++++++
 tb/tb_toggle_decoder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_decoder.sv
// rtl/toggle_decoder.sv - toggle-line event decoder: pulse, saturating count, idle/active/stall watchdog.
// Optional input synchronizer compiled in with TOGGLE_DECODER_SYNC_EN.
module toggle_decoder #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             toggle_in,
  output logic             pulse_out,
  output logic [CNT_W-1:0] count,
  output logic             sat,
  output logic             active,
  output logic             stalled
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [TW-1:0]    T_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_STALL} state_t;

  logic line_in;
  logic line_q, line_d, line_dly_q, line_dly_d;
  logic pulse_q, pulse_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic sat_q, sat_d;
  logic [TW-1:0] timer_q, timer_d;
  state_t state_q, state_d;
  logic ev;

`ifdef TOGGLE_DECODER_SYNC_EN
  logic sync1_q, sync1_d, sync2_q, sync2_d;

  always_comb begin
    sync1_d = toggle_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign line_in = sync2_q;
`else
  assign line_in = toggle_in;
`endif

  // Samplers run regardless of enable, so a disabled transition is consumed.
  assign ev = (line_q ^ line_dly_q) & enable;

  always_comb begin
    line_d     = line_in;
    line_dly_d = line_q;
    pulse_d    = ev;
    count_d    = count_q;
    sat_d      = sat_q;
    if (clear) begin
      count_d = '0;
      sat_d   = 1'b0;
    end else begin
      if (ev && (count_q != CNT_MAX)) count_d = count_q + 1'b1;
      sat_d = sat_q | (count_d == CNT_MAX);
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (clear) begin
      state_d = ST_IDLE;
      timer_d = '0;
    end else if (enable) begin
      case (state_q)
        ST_IDLE, ST_STALL: begin
          if (ev) begin
            state_d = ST_ACTIVE;
            timer_d = '0;
          end
        end
        ST_ACTIVE: begin
          if (ev) begin
            timer_d = '0;
          end else if (timer_q == T_LAST) begin
            state_d = ST_STALL;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_q     <= 1'b0;
      line_dly_q <= 1'b0;
      pulse_q    <= 1'b0;
      count_q    <= '0;
      sat_q      <= 1'b0;
      timer_q    <= '0;
      state_q    <= ST_IDLE;
    end else begin
      line_q     <= line_d;
      line_dly_q <= line_dly_d;
      pulse_q    <= pulse_d;
      count_q    <= count_d;
      sat_q      <= sat_d;
      timer_q    <= timer_d;
      state_q    <= state_d;
    end
  end

  assign pulse_out = pulse_q;
  assign count     = count_q;
  assign sat       = sat_q;
  assign active    = (state_q == ST_ACTIVE);
  assign stalled   = (state_q == ST_STALL);

endmodule

// File: tb/tb_toggle_decoder.sv
// tb/tb_toggle_decoder.sv - scoreboard bench for toggle_decoder (CNT_W=8 and CNT_W=3 instances).
module tb_toggle_decoder;

`ifdef TOGGLE_DECODER_SYNC_EN
  localparam int NS = 4;
`else
  localparam int NS = 2;
`endif
  localparam int LAT = NS - 1;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic clear = 1'b0;
  logic toggle_in = 1'b0;

  logic       pulse8, sat8, act8, stl8;
  logic [7:0] count8;
  logic       pulse3, sat3, act3, stl3;
  logic [2:0] count3;

  toggle_decoder #(.CNT_W(8), .TIMEOUT(TMO)) dut8 (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .toggle_in(toggle_in),
    .pulse_out(pulse8), .count(count8), .sat(sat8), .active(act8), .stalled(stl8)
  );

  toggle_decoder #(.CNT_W(3), .TIMEOUT(TMO)) dut3 (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .toggle_in(toggle_in),
    .pulse_out(pulse3), .count(count3), .sat(sat3), .active(act3), .stalled(stl3)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model, advanced once per rising edge from the inputs applied to it.
  logic [3:0] m_pipe;
  int m_pulse, m_c8, m_s8, m_c3, m_s3, m_st, m_tmr;
  logic [31:0] exp_q[$];
  int edge_n = 0;

  task automatic model_reset();
    m_pipe = '0;
    m_pulse = 0; m_c8 = 0; m_s8 = 0; m_c3 = 0; m_s3 = 0; m_st = 0; m_tmr = 0;
  endtask

  task automatic model_step(input logic tg, input logic en, input logic cl);
    int ev;
    ev = ((m_pipe[NS-2] ^ m_pipe[NS-1]) && en) ? 1 : 0;
    m_pulse = ev;
    if (cl) begin
      m_c8 = 0; m_c3 = 0; m_s8 = 0; m_s3 = 0; m_st = 0; m_tmr = 0;
    end else begin
      if (ev == 1 && m_c8 < 255) m_c8++;
      if (ev == 1 && m_c3 < 7) m_c3++;
      if (m_c8 == 255) m_s8 = 1;
      if (m_c3 == 7) m_s3 = 1;
      if (en) begin
        if (m_st == 1) begin
          if (ev == 1) m_tmr = 0;
          else if (m_tmr == TMO - 1) begin m_st = 2; m_tmr = 0; end
          else m_tmr++;
        end else if (ev == 1) begin
          m_st = 1; m_tmr = 0;
        end
      end
    end
    m_pipe = {m_pipe[2:0], tg};
  endtask

  function automatic logic [31:0] exp_vec();
    logic p, a, s;
    p = (m_pulse != 0);
    a = (m_st == 1);
    s = (m_st == 2);
    return {13'b0, p, 8'(m_c8), (m_s8 != 0), 3'(m_c3), (m_s3 != 0), a, s, p, a, s};
  endfunction

  function automatic logic [31:0] got_vec();
    return {13'b0, pulse8, count8, sat8, count3, sat3, act8, stl8, pulse3, act3, stl3};
  endfunction

  task automatic cyc(input logic tg, input logic en, input logic cl);
    toggle_in = tg; enable = en; clear = cl;
    @(posedge clk);
    edge_n++;
    if (reset) model_reset();
    else model_step(tg, en, cl);
    exp_q.push_back(exp_vec());
    @(negedge clk);
  endtask

  // Monitor: pops one expectation per cycle and tracks pulse/stall timing.
  int pulses_seen = 0;
  int last_pulse_edge = 0;
  int stall_delay = -1;
  int cur_run = 0;
  int last_run = 0;
  logic prev_stl = 1'b0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) check_eq("cycle", got_vec(), exp_q.pop_front());
    if (pulse8) begin
      pulses_seen++;
      last_pulse_edge = edge_n;
      cur_run++;
    end else begin
      if (cur_run > 0) last_run = cur_run;
      cur_run = 0;
    end
    if (stl8 && !prev_stl) stall_delay = edge_n - last_pulse_edge;
    prev_stl = stl8;
  end

  task automatic async_reset(input logic tg);
    toggle_in = tg;
    #2 reset = 1'b1;
    #1;
    check_eq("rst_pulse", {31'b0, pulse8 | pulse3}, 0);
    check_eq("rst_count", {21'b0, count8, count3}, 0);
    check_eq("rst_flags", {26'b0, sat8, sat3, act8, act3, stl8, stl3}, 0);
    model_reset();
    @(negedge clk);
    cyc(tg, 1'b1, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    logic t;
    int k, p0, c0;
    t = 1'b0;
    model_reset();

    repeat (2) cyc(1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    repeat (3) cyc(1'b0, 1'b1, 1'b0);
    check_eq("idle_no_pulse", pulses_seen, 0);

    // single event and its latency
    t = 1'b1;
    k = edge_n + 1;
    cyc(t, 1'b1, 1'b0);
    repeat (5) cyc(t, 1'b1, 1'b0);
    check_eq("latency", last_pulse_edge - k, LAT);
    check_eq("single_count", {24'b0, count8}, 1);
    check_eq("single_active", {31'b0, act8}, 1);

    // stall after TIMEOUT quiet cycles, recovery on next transition
    repeat (20) cyc(t, 1'b1, 1'b0);
    check_eq("stall_delay", stall_delay, TMO);
    check_eq("stalled", {31'b0, stl8}, 1);
    t = 1'b0;
    repeat (5) cyc(t, 1'b1, 1'b0);
    check_eq("recover", {30'b0, act8, stl8}, 2);

    // asynchronous reset mid-operation, released with line at 0
    async_reset(1'b0);
    p0 = pulses_seen;
    repeat (6) cyc(t, 1'b1, 1'b0);
    check_eq("rst0_no_pulse", pulses_seen - p0, 0);

    // continuous toggling
    for (int i = 0; i < 20; i++) begin
      t = ~t;
      cyc(t, 1'b1, 1'b0);
    end
    repeat (LAT + 2) cyc(t, 1'b1, 1'b0);
    check_eq("run_len", last_run, 20);
    check_eq("run_count", {24'b0, count8}, 20);

    // saturation of the 3-bit counter
    cyc(t, 1'b1, 1'b1);
    p0 = pulses_seen;
    for (int i = 0; i < 9; i++) begin
      t = ~t;
      cyc(t, 1'b1, 1'b0);
      cyc(t, 1'b1, 1'b0);
    end
    repeat (LAT + 1) cyc(t, 1'b1, 1'b0);
    check_eq("sat_pulses", pulses_seen - p0, 9);
    check_eq("sat_count3", {29'b0, count3}, 7);
    check_eq("sat_flag3", {31'b0, sat3}, 1);
    check_eq("sat_count8", {24'b0, count8}, 9);
    cyc(t, 1'b1, 1'b1);
    check_eq("clr_count3", {28'b0, count3, sat3}, 0);
    check_eq("clr_fsm", {30'b0, act3, stl3}, 0);

    // transition while disabled is lost
    c0 = int'(count8);
    p0 = pulses_seen;
    t = ~t;
    repeat (NS + 1) cyc(t, 1'b0, 1'b0);
    repeat (3) cyc(t, 1'b1, 1'b0);
    check_eq("dis_count", {24'b0, count8}, c0);
    check_eq("dis_pulse", pulses_seen - p0, 0);

    // clear coincident with an event
    p0 = pulses_seen;
    t = ~t;
    cyc(t, 1'b1, 1'b0);
    repeat (NS - 2) cyc(t, 1'b1, 1'b0);
    cyc(t, 1'b1, 1'b1);
    check_eq("clr_ev_pulse", {31'b0, pulse8}, 1);
    repeat (3) cyc(t, 1'b1, 1'b0);
    check_eq("clr_ev_count", {24'b0, count8}, 0);
    check_eq("clr_ev_idle", {30'b0, act8, stl8}, 0);
    check_eq("clr_ev_pulses", pulses_seen - p0, 1);

    // reset with the line held high yields one event after release
    if (t == 1'b0) begin
      t = 1'b1;
      repeat (NS + 2) cyc(t, 1'b1, 1'b0);
    end
    async_reset(1'b1);
    p0 = pulses_seen;
    repeat (NS + 3) cyc(t, 1'b1, 1'b0);
    check_eq("rst1_pulses", pulses_seen - p0, 1);
    check_eq("rst1_count", {24'b0, count8}, 1);

    @(negedge clk);
    check_eq("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
